// File: rtl/vic_pkg.sv
// Shared definitions for the VIC configuration register access path.
//   VIC_ADDR_W   : register file address width
//   VIC_DATA_W   : register file data width
//   VIC_NUM_REGS : number of registers in the file
//   state_e      : access controller FSM states
package vic_pkg;

   localparam int unsigned VIC_ADDR_W   = 5;
   localparam int unsigned VIC_DATA_W   = 4;
   localparam int unsigned VIC_NUM_REGS = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/vic_reg_ctrl_if.sv
// Requester-side bus of the VIC register access controller.
//   req   : per-requester access request, held until the matching ack
//   we    : per-requester write (1) / read (0)
//   addr  : flattened addresses, slice k = [5k+4:5k]
//   wdata : flattened write data, slice k = [4k+3:4k]
//   ack   : one-cycle completion pulse per requester
//   rdata : read data, valid while ack is non-zero for a read
//   busy  : controller is not idle
// master = requester side, slave = controller side.
interface vic_reg_ctrl_if #(
   parameter int unsigned N_REQ = 2
);
   import vic_pkg::*;

   logic [N_REQ-1:0]            req;
   logic [N_REQ-1:0]            we;
   logic [VIC_ADDR_W*N_REQ-1:0] addr;
   logic [VIC_DATA_W*N_REQ-1:0] wdata;
   logic [N_REQ-1:0]            ack;
   logic [VIC_DATA_W-1:0]       rdata;
   logic                        busy;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata, busy
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata, busy
   );

endinterface

// File: rtl/vic_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : index where the search starts (wraps modulo N_REQ)
//   gnt       : one-hot grant
//   gnt_idx   : index of the granted requester
//   gnt_valid : at least one request present
module vic_rr_arbiter #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [PTR_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   logic [PTR_W-1:0] cand;

   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      cand      = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = PTR_W'((32'(ptr) + i) % N_REQ);
         if (!gnt_valid && req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vic_reg_ctrl.sv
// Access controller for the VIC configuration register file.
// Arbitrates N_REQ requesters round-robin and runs each granted access as
// IDLE -> ACCESS -> DONE. Every output comes straight from a register.
//   i_clk         : system clock, rising edge
//   i_rst_n       : asynchronous active-low reset
//   bus           : requester bus (slave modport), N_REQ must match
//   o_VIC_regaddr : register file address
//   o_VIC_data    : register file write data
//   o_VIC_we      : register file write enable
//   o_VIC_re      : register file read enable
//   i_VIC_data    : register file read data
module vic_reg_ctrl
   import vic_pkg::*;
#(
   parameter int unsigned N_REQ = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   vic_reg_ctrl_if.slave         bus,
   output logic [VIC_ADDR_W-1:0] o_VIC_regaddr,
   output logic [VIC_DATA_W-1:0] o_VIC_data,
   output logic                  o_VIC_we,
   output logic                  o_VIC_re,
   input  logic [VIC_DATA_W-1:0] i_VIC_data
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_e                state_q, state_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [PTR_W-1:0]      win_q, win_d;
   logic [N_REQ-1:0]      win_oh_q, win_oh_d;
   logic [VIC_ADDR_W-1:0] regaddr_q, regaddr_d;
   logic [VIC_DATA_W-1:0] vdata_q, vdata_d;
   logic                  vwe_q, vwe_d;
   logic                  vre_q, vre_d;
   logic [N_REQ-1:0]      ack_q, ack_d;
   logic [VIC_DATA_W-1:0] rdata_q, rdata_d;
   logic                  busy_q, busy_d;

   logic [N_REQ-1:0]      gnt;
   logic [PTR_W-1:0]      gnt_idx;
   logic                  gnt_valid;
   logic [VIC_ADDR_W-1:0] sel_addr;
   logic [VIC_DATA_W-1:0] sel_wdata;

   vic_rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req       (bus.req),
      .ptr       (ptr_q),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   assign sel_addr  = bus.addr[gnt_idx*VIC_ADDR_W +: VIC_ADDR_W];
   assign sel_wdata = bus.wdata[gnt_idx*VIC_DATA_W +: VIC_DATA_W];

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         win_q     <= '0;
         win_oh_q  <= '0;
         regaddr_q <= '0;
         vdata_q   <= '0;
         vwe_q     <= 1'b0;
         vre_q     <= 1'b0;
         ack_q     <= '0;
         rdata_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         win_oh_q  <= win_oh_d;
         regaddr_q <= regaddr_d;
         vdata_q   <= vdata_d;
         vwe_q     <= vwe_d;
         vre_q     <= vre_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
         busy_q    <= busy_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (gnt_valid) state_d = ACCESS;
         ACCESS:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs. The VIC port and ack default
   // to zero so they are only ever high for their single cycle.
   always_comb begin
      ptr_d     = ptr_q;
      win_d     = win_q;
      win_oh_d  = win_oh_q;
      regaddr_d = '0;
      vdata_d   = '0;
      vwe_d     = 1'b0;
      vre_d     = 1'b0;
      ack_d     = '0;
      rdata_d   = rdata_q;
      busy_d    = (state_d != IDLE);
      unique case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               win_d     = gnt_idx;
               win_oh_d  = gnt;
               regaddr_d = sel_addr;
               vdata_d   = sel_wdata;
               vwe_d     = bus.we[gnt_idx];
               vre_d     = ~bus.we[gnt_idx];
            end
         end
         ACCESS: begin
            // vre_q doubles as the latched "this access is a read" flag
            if (vre_q) rdata_d = i_VIC_data;
            ack_d = win_oh_q;
         end
         DONE: begin
            ptr_d = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.ack       = ack_q;
   assign bus.rdata     = rdata_q;
   assign bus.busy      = busy_q;
   assign o_VIC_regaddr = regaddr_q;
   assign o_VIC_data    = vdata_q;
   assign o_VIC_we      = vwe_q;
   assign o_VIC_re      = vre_q;

endmodule

// File: tb/tb_vic_reg_ctrl.sv
// Self-checking bench for vic_reg_ctrl with a behavioural register file
// (OR-in writes, cleared by reset, combinational read while re is high).
module tb_vic_reg_ctrl;
   import vic_pkg::*;

   localparam int unsigned N = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vic_reg_ctrl_if #(.N_REQ(N)) bus ();

   logic [VIC_ADDR_W-1:0] vic_addr;
   logic [VIC_DATA_W-1:0] vic_wdata;
   logic                  vic_we;
   logic                  vic_re;
   logic [VIC_DATA_W-1:0] vic_rdata;

   vic_reg_ctrl #(.N_REQ(N)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .bus           (bus),
      .o_VIC_regaddr (vic_addr),
      .o_VIC_data    (vic_wdata),
      .o_VIC_we      (vic_we),
      .o_VIC_re      (vic_re),
      .i_VIC_data    (vic_rdata)
   );

   // Register file model
   logic [VIC_DATA_W-1:0] mem [VIC_NUM_REGS];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(VIC_NUM_REGS); i++) mem[i] <= '0;
      end else if (vic_we) begin
         mem[vic_addr] <= mem[vic_addr] | vic_wdata;
      end
   end
   assign vic_rdata = vic_re ? mem[vic_addr] : '0;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct packed {
      logic [N-1:0] mask;
      logic         is_read;
      logic [3:0]   rdata;
   } exp_t;
   exp_t sb[$];

   function automatic exp_t mk(logic [N-1:0] m, logic r, logic [3:0] d);
      exp_t e;
      e.mask = m; e.is_read = r; e.rdata = d;
      return e;
   endfunction

   // Scoreboard monitor: every ack is popped against the expected queue
   always @(negedge clk) begin
      exp_t e;
      if (vic_we || vic_re) begin
         n_vec++;
         if (vic_we && vic_re) begin
            n_err++;
            $display("FAIL we_re_exclusive: we=%b re=%b at cycle %0d, required not both", vic_we,
                     vic_re, cyc);
         end
      end
      if (bus.ack !== '0) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_ack: ack=%b at cycle %0d, required none", bus.ack, cyc);
         end else begin
            e = sb.pop_front();
            if (bus.ack !== e.mask) begin
               n_err++;
               $display("FAIL sb_ack: ack=%b, required %b", bus.ack, e.mask);
            end
            if (e.is_read) begin
               n_vec++;
               if (bus.rdata !== e.rdata) begin
                  n_err++;
                  $display("FAIL sb_rdata: rdata=%h, required %h", bus.rdata, e.rdata);
               end
            end
         end
      end
   end

   task automatic set_req(input int k, input logic w, input logic [4:0] a, input logic [3:0] d);
      bus.req[k]           = 1'b1;
      bus.we[k]            = w;
      bus.addr[k*5 +: 5]   = a;
      bus.wdata[k*4 +: 4]  = d;
   endtask

   task automatic wait_ack(input int k, input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (bus.ack[k]) seen = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({bus.ack, bus.rdata, bus.busy, vic_addr, vic_wdata, vic_we, vic_re} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: ack=%b rdata=%h busy=%b addr=%h data=%h we=%b re=%b, required 0",
                  bus.ack, bus.rdata, bus.busy, vic_addr, vic_wdata, vic_we, vic_re);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({bus.ack, bus.busy, vic_we, vic_re} !== '0) begin
         n_err++;
         $display("FAIL post_reset_idle: ack=%b busy=%b we=%b re=%b, required 0", bus.ack,
                  bus.busy, vic_we, vic_re);
      end
   endtask

   task automatic test_write_read();
      @(negedge clk);                              // cycle 0
      sb.push_back(mk(2'b01, 1'b0, 4'h0));
      set_req(0, 1'b1, 5'd5, 4'hA);
      @(negedge clk);                              // cycle 1
      n_vec++;
      if ({vic_we, vic_re, vic_addr, vic_wdata, bus.busy, bus.ack} !==
          {1'b1, 1'b0, 5'd5, 4'hA, 1'b1, 2'b00}) begin
         n_err++;
         $display("FAIL wr_access: we=%b re=%b addr=%0d data=%h busy=%b ack=%b, required 1 0 5 a 1 00",
                  vic_we, vic_re, vic_addr, vic_wdata, bus.busy, bus.ack);
      end
      @(negedge clk);                              // cycle 2
      n_vec++;
      if ({bus.ack, vic_we, vic_re, bus.busy} !== {2'b01, 1'b0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL wr_ack: ack=%b we=%b re=%b busy=%b, required 01 0 0 1", bus.ack, vic_we,
                  vic_re, bus.busy);
      end
      bus.req[0] = 1'b0;
      @(negedge clk);                              // idle cycle
      sb.push_back(mk(2'b01, 1'b1, 4'hA));
      set_req(0, 1'b0, 5'd5, 4'h0);
      @(negedge clk);
      n_vec++;
      if ({vic_we, vic_re, vic_addr} !== {1'b0, 1'b1, 5'd5}) begin
         n_err++;
         $display("FAIL rd_access: we=%b re=%b addr=%0d, required 0 1 5", vic_we, vic_re, vic_addr);
      end
      @(negedge clk);
      n_vec++;
      if ({bus.ack, bus.rdata} !== {2'b01, 4'hA}) begin
         n_err++;
         $display("FAIL rd_ack: ack=%b rdata=%h, required 01 a", bus.ack, bus.rdata);
      end
      bus.req[0] = 1'b0;
   endtask

   task automatic test_simultaneous();
      bit seen;
      do_reset();
      @(negedge clk);                              // cycle 0
      sb.push_back(mk(2'b01, 1'b1, 4'h0));
      sb.push_back(mk(2'b10, 1'b0, 4'h0));
      set_req(0, 1'b0, 5'd3, 4'h0);
      set_req(1, 1'b1, 5'd7, 4'h5);
      @(negedge clk);                              // cycle 1
      n_vec++;
      if ({vic_we, vic_re, vic_addr} !== {1'b0, 1'b1, 5'd3}) begin
         n_err++;
         $display("FAIL sim_first_access: we=%b re=%b addr=%0d, required 0 1 3", vic_we, vic_re,
                  vic_addr);
      end
      @(negedge clk);                              // cycle 2
      n_vec++;
      if (bus.ack !== 2'b01) begin
         n_err++;
         $display("FAIL sim_ack0_cycle2: ack=%b, required 01", bus.ack);
      end
      bus.req[0] = 1'b0;
      @(negedge clk);                              // cycle 3
      n_vec++;
      if ({bus.busy, bus.ack} !== 3'b000) begin
         n_err++;
         $display("FAIL sim_idle_gap: busy=%b ack=%b, required 0 00", bus.busy, bus.ack);
      end
      @(negedge clk);                              // cycle 4
      n_vec++;
      if ({vic_we, vic_re, vic_addr, vic_wdata} !== {1'b1, 1'b0, 5'd7, 4'h5}) begin
         n_err++;
         $display("FAIL sim_second_access: we=%b re=%b addr=%0d data=%h, required 1 0 7 5", vic_we,
                  vic_re, vic_addr, vic_wdata);
      end
      @(negedge clk);                              // cycle 5
      n_vec++;
      if (bus.ack !== 2'b10) begin
         n_err++;
         $display("FAIL sim_ack1_cycle5: ack=%b, required 10", bus.ack);
      end
      bus.req[1] = 1'b0;
      // Pointer wrapped back to 0: requester 0 must win again
      @(negedge clk);
      sb.push_back(mk(2'b01, 1'b1, 4'h0));
      sb.push_back(mk(2'b10, 1'b1, 4'h5));
      set_req(0, 1'b0, 5'd3, 4'h0);
      set_req(1, 1'b0, 5'd7, 4'h0);
      repeat (2) @(negedge clk);
      n_vec++;
      if (bus.ack !== 2'b01) begin
         n_err++;
         $display("FAIL sim_ptr_wrap: ack=%b, required 01", bus.ack);
      end
      bus.req[0] = 1'b0;
      wait_ack(1, 6, seen);
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL sim_ptr_wrap_ack1: seen=0, required 1");
      end
      bus.req[1] = 1'b0;
   endtask

   task automatic test_fairness();
      bit seen;
      int last;
      logic [N-1:0] m;
      last = -1;
      @(negedge clk);
      for (int n = 0; n < 6; n++) begin
         if (n % 2 == 0) sb.push_back(mk(2'b01, 1'b1, 4'h0));
         else            sb.push_back(mk(2'b10, 1'b1, 4'h5));
      end
      set_req(0, 1'b0, 5'd3, 4'h0);
      set_req(1, 1'b0, 5'd7, 4'h0);
      for (int n = 0; n < 6; n++) begin
         m = '0;
         m[n % 2] = 1'b1;
         seen = 1'b0;
         for (int t = 0; t < 5 && !seen; t++) begin
            @(negedge clk);
            if (bus.ack !== '0) seen = 1'b1;
         end
         n_vec++;
         if (!seen || bus.ack !== m) begin
            n_err++;
            $display("FAIL fair_order_%0d: ack=%b seen=%b, required %b", n, bus.ack, seen, m);
         end
         if (last >= 0) begin
            n_vec++;
            if (cyc - last != 3) begin
               n_err++;
               $display("FAIL fair_spacing_%0d: gap=%0d, required 3", n, cyc - last);
            end
         end
         last = cyc;
      end
      bus.req = '0;
   endtask

   task automatic test_mid_change();
      bit seen;
      @(negedge clk);
      sb.push_back(mk(2'b01, 1'b0, 4'h0));
      set_req(0, 1'b1, 5'd2, 4'h3);
      wait_ack(0, 6, seen);
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL mid_setup_ack: seen=0, required 1");
      end
      bus.req[0] = 1'b0;
      @(negedge clk);
      sb.push_back(mk(2'b10, 1'b1, 4'h3));
      set_req(1, 1'b0, 5'd2, 4'h0);
      @(posedge clk);
      #1;                                          // now in ACCESS
      bus.addr[9:5]  = 5'd9;
      bus.we[1]      = 1'b1;
      bus.wdata[7:4] = 4'hF;
      @(negedge clk);
      n_vec++;
      if ({vic_addr, vic_re, vic_we} !== {5'd2, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL mid_hold: addr=%0d re=%b we=%b, required 2 1 0", vic_addr, vic_re, vic_we);
      end
      wait_ack(1, 6, seen);
      n_vec++;
      if (!seen || bus.rdata !== 4'h3) begin
         n_err++;
         $display("FAIL mid_rdata: seen=%b rdata=%h, required 1 3", seen, bus.rdata);
      end
      bus.req[1] = 1'b0;
      bus.we[1]  = 1'b0;
      // The late change must not have produced a write to address 9
      @(negedge clk);
      sb.push_back(mk(2'b01, 1'b1, 4'h0));
      set_req(0, 1'b0, 5'd9, 4'h0);
      wait_ack(0, 6, seen);
      n_vec++;
      if (!seen || bus.rdata !== 4'h0) begin
         n_err++;
         $display("FAIL mid_no_write9: seen=%b rdata=%h, required 1 0", seen, bus.rdata);
      end
      bus.req[0] = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      bit seen;
      // Let requester 0 go first so the pointer is 1 before the abort
      @(negedge clk);
      sb.push_back(mk(2'b01, 1'b1, 4'h0));
      set_req(0, 1'b0, 5'd0, 4'h0);
      wait_ack(0, 6, seen);
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL rst_setup_ack: seen=0, required 1");
      end
      bus.req[0] = 1'b0;
      @(negedge clk);
      set_req(1, 1'b1, 5'd12, 4'hF);
      @(posedge clk);
      #1;
      n_vec++;
      if ({vic_we, vic_addr} !== {1'b1, 5'd12}) begin
         n_err++;
         $display("FAIL rst_pre_access: we=%b addr=%0d, required 1 12", vic_we, vic_addr);
      end
      rst_n = 1'b0;
      bus.req = '0;
      #1;
      n_vec++;
      if ({bus.ack, bus.rdata, bus.busy, vic_addr, vic_wdata, vic_we, vic_re} !== '0) begin
         n_err++;
         $display("FAIL rst_immediate: ack=%b rdata=%h busy=%b addr=%h data=%h we=%b re=%b, required 0",
                  bus.ack, bus.rdata, bus.busy, vic_addr, vic_wdata, vic_we, vic_re);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back(mk(2'b01, 1'b1, 4'h0));
      sb.push_back(mk(2'b10, 1'b1, 4'h0));
      set_req(0, 1'b0, 5'd12, 4'h0);
      set_req(1, 1'b0, 5'd12, 4'h0);
      seen = 1'b0;
      for (int t = 0; t < 5 && !seen; t++) begin
         @(negedge clk);
         if (bus.ack !== '0) seen = 1'b1;
      end
      n_vec++;
      if (!seen || bus.ack !== 2'b01 || bus.rdata !== 4'h0) begin
         n_err++;
         $display("FAIL rst_next_grant: ack=%b rdata=%h, required 01 0", bus.ack, bus.rdata);
      end
      bus.req[0] = 1'b0;
      wait_ack(1, 6, seen);
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL rst_second_grant: seen=0, required 1");
      end
      bus.req[1] = 1'b0;
   endtask

   task automatic test_idle();
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_vec++;
         if ({bus.busy, bus.ack, vic_addr, vic_wdata, vic_we, vic_re} !== '0) begin
            n_err++;
            $display("FAIL idle_%0d: busy=%b ack=%b addr=%h data=%h we=%b re=%b, required 0", i,
                     bus.busy, bus.ack, vic_addr, vic_wdata, vic_we, vic_re);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_simultaneous();
      test_fairness();
      test_mid_change();
      test_reset_mid_access();
      test_idle();
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL sb_drained: %0d entries left, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vic_reg_ctrl.md
# vic_reg_ctrl

Access controller for the VIC configuration register file (32 registers × 4 bits, single address/data/we/re port). It arbitrates up to N_REQ requesters with a round-robin scheme and runs each granted access as a fixed three-state sequence. It drives the register file's access port with registered signals and returns read data with a per-requester acknowledge. It sits between the host bus bridge and interrupt-status updaters on one side and `vic_registers` on the other.

## Interface
- N_REQ, 2, number of requesters (2..4)
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req  in  N_REQ  per-requester access request; hold high until matching ack
- i_we  in  N_REQ  per-requester 1 = write, 0 = read
- i_addr  in  5*N_REQ  flattened register addresses; slice k = [5k+4:5k]
- i_wdata  in  4*N_REQ  flattened write data; slice k = [4k+3:4k]
- o_ack  out  N_REQ  one-cycle pulse: access for requester k complete
- o_rdata  out  4  read data, valid only while o_ack is non-zero and the access was a read
- o_busy  out  1  high whenever the FSM is not in IDLE
- o_VIC_regaddr  out  5  register file address
- o_VIC_data  out  4  register file write data
- o_VIC_we  out  1  register file write enable
- o_VIC_re  out  1  register file read enable
- i_VIC_data  in  4  register file read data (combinational from the file while re is high)

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any i_req bit is high, the arbiter picks a winner. The winner's addr, wdata and we are latched. o_VIC_regaddr and o_VIC_data are loaded, and exactly one of o_VIC_we/o_VIC_re is set. The FSM goes to ACCESS. With no request, the FSM stays in IDLE and all VIC outputs are 0.
- ACCESS, always one cycle: the VIC outputs are held. For a read, i_VIC_data is captured into o_rdata at the end of the cycle. The FSM goes to DONE, and o_VIC_we, o_VIC_re, o_VIC_regaddr and o_VIC_data return to 0.
- DONE, always one cycle: o_ack[winner] = 1. The round-robin pointer is set to winner+1 (mod N_REQ). The FSM goes to IDLE.
- Round-robin: the search starts at the pointer and increments modulo N_REQ. The first requester with req high wins. The pointer resets to 0.
- A request is sampled only in IDLE. Changes to req, we, addr or wdata during ACCESS or DONE are ignored for the access in flight.
- If a requester keeps req high in the IDLE cycle after its ack, this is a new request. It competes normally, and the updated pointer gives the other requesters priority.
- o_rdata holds its last value outside ack. On a write ack it is unchanged.
- Writes follow register-file semantics: the file ORs data in. The controller does not read-modify-write.
- Asynchronous reset, including mid-access: the FSM goes to IDLE and the pointer to 0. o_ack, o_rdata, o_busy and all o_VIC_* are 0. An access aborted by reset gets no ack. A write aborted in ACCESS by reset is never committed, because the register file is also under reset.

## Timing
- All outputs are registered. There is no combinational path from the requester inputs (i_req/i_we/i_addr/i_wdata) to any output.
- Latency: request sampled in IDLE at cycle 0. o_VIC_we or o_VIC_re is high during cycle 1. o_ack is high during cycle 2.
- Throughput: one access per 3 cycles; continuous requests give back-to-back IDLE→ACCESS→DONE.
- A write issued in ACCESS at cycle n is visible to a read whose ACCESS cycle is n+3 or later.
- o_busy is high in ACCESS and DONE, and low in IDLE.
- o_VIC_we and o_VIC_re are never high together, and each is high for exactly one cycle per access.

## Structure
- Shared package `vic_pkg` holds:
  - VIC_ADDR_W = 5, VIC_DATA_W = 4, VIC_NUM_REGS = 32.
  - The state enum {IDLE, ACCESS, DONE}.
- Sub-module `vic_rr_arbiter` is parameterised by N_REQ. It takes the request vector and the pointer, and produces a one-hot grant, the grant index and a grant-valid flag. It is combinational; the pointer register stays in vic_reg_ctrl.

## Test plan
- Single write, then read: req0 writes addr 5, data 0xA, then reads addr 5.
  - Write: o_VIC_we high in cycle 1 with regaddr 5 and data 0xA; ack[0] in cycle 2.
  - Read: o_VIC_re high in its ACCESS cycle; ack[0] with o_rdata = 0xA.
- Simultaneous requests with pointer 0: req0 reads addr 3, req1 writes addr 7 with 0x5.
  - req0 is served first (ack[0] in cycle 2), then req1 (ack[1] in cycle 5).
  - The pointer afterwards is 0.
- Fairness: both requesters hold req high for 6 accesses.
  - Acks alternate 0,1,0,1,0,1, each 3 cycles apart.
  - o_VIC_we/re are never high together.
- Inputs changed mid-access: req1 reads addr 2 (file value 0x3), and addr is changed to 9 during ACCESS.
  - o_VIC_regaddr stays 2, and o_rdata = 0x3.
- Reset mid-access: i_rst_n is pulled low during ACCESS of a write.
  - All outputs go 0 immediately, with no ack.
  - After release, a read of that address returns 0x0, and the next grant goes to requester 0.
- Idle behaviour: no requests for 10 cycles.
  - o_busy = 0, o_ack = 0, and all o_VIC_* stay 0.
